// File: rtl/adder_delay_meas_ctrl_if.sv
// Host/adder-side signal bundle for the Kogge-Stone delay measurement sequencer.
// master = host plus ring counter source, slave = sequencer.
interface adder_delay_meas_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int REP_W = 4,
  parameter int ACC_W = 24
);
  logic              active;
  logic              start;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [31:0]       ring_sel;
  logic [WIN_W-1:0]  window;
  logic [REP_W-1:0]  reps;
  logic [CNT_W-1:0]  cnt_in;
  logic [31:0]       adder_a;
  logic [31:0]       adder_b;
  logic [31:0]       ring_bit;
  logic              cnt_clear;
  logic              osc_en;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic              err;

  modport master (
    output active, start, op_a, op_b, ring_sel, window, reps, cnt_in,
    input  adder_a, adder_b, ring_bit, cnt_clear, osc_en, busy, done, result, err
  );

  modport slave (
    input  active, start, op_a, op_b, ring_sel, window, reps, cnt_in,
    output adder_a, adder_b, ring_bit, cnt_clear, osc_en, busy, done, result, err
  );
endinterface

// File: rtl/adder_delay_meas_ctrl.sv
// Measurement sequencer: load operands, settle, gate the ring oscillator for a window,
// drain, accumulate the ring count over reps+1 runs and report a saturated sum.
//
// state    | meaning
// IDLE     | waiting for start while active
// LOAD     | operands applied, ring counter cleared
// SETTLE   | operands static, oscillator gated off
// RUN      | oscillator gate open for window cycles
// DRAIN    | gate closed, counter settling before sample
// ACCUM    | add cnt_in to accumulator, loop or finish
// DONE     | result published, done pulse
module adder_delay_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int REP_W      = 4,
  parameter int ACC_W      = 24,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 3
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  adder_delay_meas_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_ACCUM, S_DONE
  } state_t;

  localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] DRAIN_LD  = WIN_W'(DRAIN_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);

  state_t            state, state_nxt;
  logic [WIN_W-1:0]  tmr;
  logic [WIN_W-1:0]  win_q;
  logic [REP_W-1:0]  runs_left;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sat;
  logic [ACC_W:0]    sum;
  logic [CNT_W-1:0]  cnt_s;
  logic              accept, illegal, abort, tmr_zero;
  logic              cnt_clear_d, osc_en_d, busy_d, done_d;

  assign cnt_s    = bus.cnt_in;
  assign tmr_zero = (tmr == '0);
  assign accept   = (state == S_IDLE) && bus.start && bus.active && (bus.window != '0);
  assign illegal  = (state == S_IDLE) && bus.start && bus.active && (bus.window == '0);
  assign abort    = (state != S_IDLE) && !bus.active;

  // One extra bit catches the carry out so the sum clamps instead of wrapping.
  assign sum     = {1'b0, acc} + (ACC_W+1)'(cnt_s);
  assign acc_sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_nxt = S_LOAD;
        S_LOAD:   state_nxt = S_SETTLE;
        S_SETTLE: if (tmr_zero) state_nxt = S_RUN;
        S_RUN:    if (tmr_zero) state_nxt = S_DRAIN;
        S_DRAIN:  if (tmr_zero) state_nxt = S_ACCUM;
        S_ACCUM:  state_nxt = (runs_left == '0) ? S_DONE : S_LOAD;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered versions line up with it.
  always_comb begin
    cnt_clear_d = (state_nxt == S_LOAD);
    osc_en_d    = (state_nxt == S_RUN);
    busy_d      = (state_nxt != S_IDLE);
    done_d      = (state_nxt == S_DONE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tmr <= '0;
    end else if (state_nxt == S_IDLE) begin
      tmr <= '0;
    end else if (state_nxt == S_SETTLE && state != S_SETTLE) begin
      tmr <= SETTLE_LD;
    end else if (state_nxt == S_RUN && state != S_RUN) begin
      tmr <= win_q - WIN_ONE;
    end else if (state_nxt == S_DRAIN && state != S_DRAIN) begin
      tmr <= DRAIN_LD;
    end else if (!tmr_zero) begin
      tmr <= tmr - WIN_ONE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      bus.cnt_clear <= 1'b0;
      bus.osc_en    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.adder_a   <= '0;
      bus.adder_b   <= '0;
      bus.ring_bit  <= '0;
      bus.result    <= '0;
      bus.err       <= 1'b0;
      win_q         <= '0;
      runs_left     <= '0;
      acc           <= '0;
    end else begin
      bus.cnt_clear <= cnt_clear_d;
      bus.osc_en    <= osc_en_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
      if (accept) begin
        bus.adder_a  <= bus.op_a;
        bus.adder_b  <= bus.op_b;
        bus.ring_bit <= bus.ring_sel;
        win_q        <= bus.window;
        runs_left    <= bus.reps;
        acc          <= '0;
        bus.err      <= 1'b0;
      end else if (illegal) begin
        bus.err <= 1'b1;
      end else if (abort) begin
        bus.ring_bit <= '0;
      end else if (state == S_ACCUM) begin
        acc <= acc_sat;
        if (runs_left == '0) bus.result <= acc_sat;
        else                 runs_left  <= runs_left - REP_ONE;
      end
    end
  end

endmodule
